// File: rtl/problem_stream_tx_pkg.sv
// Shared definitions for the problem stream source: FSM states, header bit positions
// and the words-per-row helper. Default widths are supplied here when the build does not set them.
`ifndef MAX_VERTSBITS
`define MAX_VERTSBITS 8
`endif
`ifndef MAX_CLIQUESIZEBITS
`define MAX_CLIQUESIZEBITS 8
`endif
`ifndef MAX_PROBSBITS
`define MAX_PROBSBITS 8
`endif

package problem_stream_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GLOBAL_HEADER,
        S_DESC_RD,
        S_PROBLEM_HEADER,
        S_PAYLOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int NOCLIQUES_BIT = 31;
    localparam int LASTPROB_BIT  = 31;

    function automatic logic [31:0] words_per_row(input logic [31:0] n);
        return (n + 32'd31) >> 5;
    endfunction

endpackage

// File: rtl/problem_stream_tx_if.sv
// Output word stream with have/want flow control.
interface problem_stream_tx_if;
    logic [31:0] o_outdata;
    logic        o_outdata_have;
    logic        i_outdata_want;

    modport master (output o_outdata, output o_outdata_have, input i_outdata_want);
    modport slave  (input o_outdata, input o_outdata_have, output i_outdata_want);
endinterface

// File: rtl/problem_stream_tx_stream_skid_fifo.sv
// Two-entry, 32-bit output FIFO. Head word and have hold steady while the consumer stalls.
module stream_skid_fifo (
    input  logic        i_clk150,
    input  logic        i_reset_n,
    input  logic        push,
    input  logic [31:0] push_data,
    output logic [1:0]  count,
    output logic [31:0] out_data,
    output logic        out_have,
    input  logic        out_want
);
    logic [1:0][31:0] mem;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign out_have = (count != 2'd0);
    assign out_data = mem[rd_ptr];
    assign pop      = out_have & out_want;

    // Push into a full FIFO is legal only together with a pop; the source guarantees it.
    always_ff @(posedge i_clk150 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/problem_stream_tx.sv
// Replays stored clique problems as a 32-bit have/want word stream: global header, then per problem
// a header and its adjacency payload. Define PROBLEM_STREAM_TX_WORDCOUNT_EN to add o_dbg_words.
module problem_stream_tx
    import problem_stream_tx_pkg::*;
#(
    parameter int VERTS_W  = `MAX_VERTSBITS,
    parameter int CLIQUE_W = `MAX_CLIQUESIZEBITS,
    parameter int PROBS_W  = `MAX_PROBSBITS,
    parameter int ADDR_W   = 16
) (
    input  logic                i_clk150,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [CLIQUE_W-1:0] i_init_maxsize,
    input  logic                i_nocliques,
    input  logic [PROBS_W-1:0]  i_nprobs,
    output logic                o_busy,
    output logic                o_done,
    output logic [PROBS_W-1:0]  o_desc_addr,
    input  logic [VERTS_W-1:0]  i_desc_nverts,
    output logic                o_mem_rd,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [31:0]         i_mem_data,
`ifdef PROBLEM_STREAM_TX_WORDCOUNT_EN
    output logic [31:0]         o_dbg_words,
`endif
    problem_stream_tx_if.master tx
);
    localparam int WC_W = 2 * VERTS_W;

    state_t state, state_n;

    logic [PROBS_W-1:0]  nprobs_q;
    logic [PROBS_W-1:0]  prob_idx;
    logic [CLIQUE_W-1:0] maxsize_q;
    logic                nocliques_q;
    logic [VERTS_W-1:0]  nverts_q;
    logic [VERTS_W-1:0]  nverts_eff;
    logic                desc_cap;
    logic [WC_W-1:0]     remaining;
    logic [WC_W-1:0]     wc;
    logic [ADDR_W-1:0]   mem_addr;
    logic                rd_q;

    logic        start_acc, hdr_push, mem_rd, adv_prob, load_rem, last_prob;
    logic [31:0] hdr_word, glob_hdr, prob_hdr;
    logic        fifo_push;
    logic [31:0] fifo_wdata;
    logic [1:0]  fifo_count;
    logic        pop;
    logic [2:0]  fill;
    logic        room;

    assign pop       = tx.o_outdata_have & tx.i_outdata_want;
    assign last_prob = (prob_idx == nprobs_q - 1'b1);

    // Descriptor data is valid only in the cycle after the read; later cycles use the captured copy.
    assign nverts_eff = desc_cap ? i_desc_nverts : nverts_q;
    assign wc = WC_W'(nverts_eff) * WC_W'(words_per_row(32'(nverts_eff)));

    // Occupancy counts the slot freed by this cycle's pop so a full-rate stream never stalls.
    assign fill = {1'b0, fifo_count} + {2'b0, rd_q} - {2'b0, pop};
    assign room = (fill < 3'd2);

    always_comb begin
        glob_hdr                           = '0;
        glob_hdr[CLIQUE_W-1:0]             = maxsize_q;
        glob_hdr[NOCLIQUES_BIT]            = nocliques_q;
        prob_hdr                           = '0;
        prob_hdr[VERTS_W-1:0]              = nverts_eff;
        prob_hdr[LASTPROB_BIT]             = last_prob;
    end

    always_ff @(posedge i_clk150 or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        hdr_push  = 1'b0;
        hdr_word  = glob_hdr;
        mem_rd    = 1'b0;
        adv_prob  = 1'b0;
        load_rem  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_n   = (i_nprobs == '0) ? S_DONE : S_GLOBAL_HEADER;
                end
            end
            S_GLOBAL_HEADER: begin
                if (!rd_q && room) begin
                    hdr_push = 1'b1;
                    state_n  = S_DESC_RD;
                end
            end
            S_DESC_RD: state_n = S_PROBLEM_HEADER;
            // Headers wait for the previous payload's last return so word order is preserved.
            S_PROBLEM_HEADER: begin
                hdr_word = prob_hdr;
                if (!rd_q && room) begin
                    hdr_push = 1'b1;
                    load_rem = 1'b1;
                    if (wc != '0)
                        state_n = S_PAYLOAD;
                    else if (last_prob)
                        state_n = S_DRAIN;
                    else begin
                        adv_prob = 1'b1;
                        state_n  = S_DESC_RD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (remaining == '0) begin
                    if (last_prob)
                        state_n = S_DRAIN;
                    else begin
                        adv_prob = 1'b1;
                        state_n  = S_DESC_RD;
                    end
                end else if (room)
                    mem_rd = 1'b1;
            end
            S_DRAIN: begin
                if (fifo_count == 2'd0 && !rd_q)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk150 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nprobs_q    <= '0;
            prob_idx    <= '0;
            maxsize_q   <= '0;
            nocliques_q <= 1'b0;
            nverts_q    <= '0;
            desc_cap    <= 1'b0;
            remaining   <= '0;
            mem_addr    <= '0;
            rd_q        <= 1'b0;
        end else begin
            desc_cap <= (state == S_DESC_RD);
            rd_q     <= mem_rd;
            if (start_acc) begin
                nprobs_q    <= i_nprobs;
                maxsize_q   <= i_init_maxsize;
                nocliques_q <= i_nocliques;
                prob_idx    <= '0;
                mem_addr    <= '0;
            end
            if (state == S_PROBLEM_HEADER)
                nverts_q <= nverts_eff;
            if (load_rem)
                remaining <= wc;
            if (mem_rd) begin
                mem_addr  <= mem_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (adv_prob)
                prob_idx <= prob_idx + 1'b1;
        end
    end

    assign fifo_push  = rd_q | hdr_push;
    assign fifo_wdata = rd_q ? i_mem_data : hdr_word;

    stream_skid_fifo u_fifo (
        .i_clk150  (i_clk150),
        .i_reset_n (i_reset_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .count     (fifo_count),
        .out_data  (tx.o_outdata),
        .out_have  (tx.o_outdata_have),
        .out_want  (tx.i_outdata_want)
    );

    assign o_busy      = (state != S_IDLE) && (state != S_DONE);
    assign o_done      = (state == S_DONE);
    assign o_desc_addr = prob_idx;
    assign o_mem_rd    = mem_rd;
    assign o_mem_addr  = mem_addr;

`ifdef PROBLEM_STREAM_TX_WORDCOUNT_EN
    always_ff @(posedge i_clk150 or negedge i_reset_n) begin
        if (!i_reset_n)
            o_dbg_words <= '0;
        else if (start_acc)
            o_dbg_words <= '0;
        else if (pop && o_dbg_words != 32'hFFFF_FFFF)
            o_dbg_words <= o_dbg_words + 32'd1;
    end
`endif
endmodule

// File: tb/tb_problem_stream_tx.sv
// Scoreboard bench for problem_stream_tx: a stream model fills the expected queue, a monitor
// pops and compares every transferred word and checks hold-during-stall.
module tb_problem_stream_tx;
    localparam int VW = 8, CW = 8, PW = 8, AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] init_maxsize = '0;
    logic          nocliques = 1'b0;
    logic [PW-1:0] nprobs = '0;
    logic          busy, done, mem_rd;
    logic [PW-1:0] desc_addr;
    logic [VW-1:0] desc_q;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_q;
    logic          want = 1'b1;
    bit            want_rand = 1'b0;
`ifdef PROBLEM_STREAM_TX_WORDCOUNT_EN
    logic [31:0]   dbg_words;
`endif

    problem_stream_tx_if tx();
    assign tx.i_outdata_want = want;

    problem_stream_tx #(.VERTS_W(VW), .CLIQUE_W(CW), .PROBS_W(PW), .ADDR_W(AW)) dut (
        .i_clk150       (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_init_maxsize (init_maxsize),
        .i_nocliques    (nocliques),
        .i_nprobs       (nprobs),
        .o_busy         (busy),
        .o_done         (done),
        .o_desc_addr    (desc_addr),
        .i_desc_nverts  (desc_q),
        .o_mem_rd       (mem_rd),
        .o_mem_addr     (mem_addr),
        .i_mem_data     (mem_q),
`ifdef PROBLEM_STREAM_TX_WORDCOUNT_EN
        .o_dbg_words    (dbg_words),
`endif
        .tx             (tx)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] desc_mem [256];
    logic [31:0]   salt = 32'h1234_5678;
    logic [31:0]   exp_q [$];
    int            n_cmp = 0, n_err = 0;
    int            case_words = 0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 16'hA5C3, a} ^ salt;
    endfunction

    // Memories: registered reads; adjacency returns junk when not read so late/early sampling shows.
    always @(posedge clk) begin
        desc_q <= desc_mem[desc_addr];
        mem_q  <= mem_rd ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 want = want_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit          stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) stall_prev = 1'b0;
        else begin
            if (stall_prev) begin
                check("hold_have", 32'(tx.o_outdata_have), 32'd1);
                check("hold_data", tx.o_outdata, prev_data);
            end
            if (tx.o_outdata_have && want) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_word: got %h expected none", tx.o_outdata);
                end else check("word", tx.o_outdata, exp_q.pop_front());
            end
            stall_prev = tx.o_outdata_have && !want;
            prev_data  = tx.o_outdata;
        end
    end

    // Reference: stream layout straight from the word-format rules.
    task automatic build_expected(input int np, input logic [CW-1:0] ms, input logic nc);
        int a = 0;
        logic [31:0] w;
        exp_q.delete();
        case_words = 0;
        if (np == 0) return;
        w = 32'(ms); w[31] = nc;
        exp_q.push_back(w);
        for (int p = 0; p < np; p++) begin
            int nv = int'(desc_mem[p]);
            int n  = nv * ((nv + 31) / 32);
            w = 32'(nv); w[31] = (p == np - 1);
            exp_q.push_back(w);
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(mem_word(AW'(a)));
                a++;
            end
        end
        case_words = exp_q.size();
    endtask

    task automatic start_stream(input int np, input logic [CW-1:0] ms, input logic nc);
        @(posedge clk);
        #1 nprobs = PW'(np); init_maxsize = ms; nocliques = nc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (np == 0) begin
            check("zero_done", 32'(done), 32'd1);
            check("zero_busy", 32'(busy), 32'd0);
        end else begin
            check("busy_rise", 32'(busy), 32'd1);
            @(posedge clk);
            #1 check("hdr_latency", 32'(tx.o_outdata_have), 32'd1);
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 20000 cycles");
        end else begin
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
            check("busy_after", 32'(busy), 32'd0);
        end
    endtask

    task automatic run_case(input int np, input logic [CW-1:0] ms, input logic nc,
                            input bit rnd, input bit mid_start);
        want_rand = rnd;
        build_expected(np, ms, nc);
        start_stream(np, ms, nc);
        if (mid_start) begin
            repeat (10) @(posedge clk);
            #1 nprobs = '0; init_maxsize = ~ms; nocliques = ~nc; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done();
`ifdef PROBLEM_STREAM_TX_WORDCOUNT_EN
        check("dbg_words", dbg_words, 32'(case_words));
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) desc_mem[i] = '0;
        salt = $urandom;
        #23;
        check("rst_have", 32'(tx.o_outdata_have), 32'd0);
        check("rst_data", tx.o_outdata, 32'd0);
        check("rst_memrd", 32'(mem_rd), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        desc_mem[0] = 8'd3;
        run_case(1, 8'd2, 1'b0, 1'b0, 1'b0);

        desc_mem[0] = 8'd40; desc_mem[1] = 8'd5;
        run_case(2, 8'd9, 1'b1, 1'b0, 1'b0);
        run_case(2, 8'd9, 1'b1, 1'b1, 1'b0);

        desc_mem[0] = 8'd33; desc_mem[1] = 8'd0; desc_mem[2] = 8'd4;
        run_case(3, 8'd7, 1'b0, 1'b1, 1'b0);

        // nprobs==0: immediate done, nothing ever presented
        want_rand = 1'b0;
        build_expected(0, 8'd1, 1'b0);
        start_stream(0, 8'd1, 1'b0);
        begin
            int seen_have = 0;
            repeat (6) begin
                @(negedge clk);
                if (tx.o_outdata_have) seen_have++;
            end
            check("zero_no_have", 32'(seen_have), 32'd0);
        end

        desc_mem[0] = 8'd40; desc_mem[1] = 8'd5;
        run_case(2, 8'd11, 1'b0, 1'b1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            int np = $urandom_range(1, 4);
            for (int p = 0; p < np; p++) desc_mem[p] = VW'($urandom_range(0, 70));
            run_case(np, CW'($urandom), 1'($urandom), 1'b1, 1'b0);
        end

        // Reset in the middle of a payload, then a clean restart from address 0
        desc_mem[0] = 8'd40; desc_mem[1] = 8'd5;
        want_rand = 1'b0;
        build_expected(2, 8'd3, 1'b0);
        start_stream(2, 8'd3, 1'b0);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_have", 32'(tx.o_outdata_have), 32'd0);
        check("midrst_memrd", 32'(mem_rd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        desc_mem[0] = 8'd3;
        run_case(1, 8'd2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/problem_stream_tx.md
Name: problem_stream_tx

Overview:
- Host-side stream source for the clique accelerator's 32-bit input word stream.
- Walks a descriptor memory (per-problem vertex count) and an adjacency word memory, and emits in order:
  - one global header;
  - for each problem: a problem header, then that problem's adjacency payload.
- Output uses the have/want handshake that the accelerator's control block consumes.
- Used on the bench/host-bridge side to replay stored problem sets into the accelerator.

Parameters:
- VERTS_W, default `MAX_VERTSBITS: vertex-count width.
- CLIQUE_W, default `MAX_CLIQUESIZEBITS: clique-size width.
- PROBS_W, default `MAX_PROBSBITS: problem-index width.
- ADDR_W, default 16: adjacency memory word-address width.

Ports:
- i_clk150  in  1  clock
- i_reset_n  in  1  reset; asynchronous, active-low
- i_start  in  1  one-cycle pulse; sampled only in S_IDLE
- i_init_maxsize  in  CLIQUE_W  global header field; latched at start
- i_nocliques  in  1  global header bit 31; latched at start
- i_nprobs  in  PROBS_W  number of problems; latched at start
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle pulse when the stream is finished
- o_desc_addr  out  PROBS_W  descriptor read address
- i_desc_nverts  in  VERTS_W  descriptor data; valid 1 cycle after the address is presented
- o_mem_rd  out  1  adjacency read strobe
- o_mem_addr  out  ADDR_W  adjacency word address
- i_mem_data  in  32  adjacency data; valid exactly 1 cycle after o_mem_rd
- o_outdata  out  32  stream word
- o_outdata_have  out  1  o_outdata is valid
- i_outdata_want  in  1  consumer ready

Behaviour:
- Handshake:
  - A word transfers in any cycle where o_outdata_have && i_outdata_want.
  - While have=1 and want=0, o_outdata and have hold.
  - have may rise independently of want.
- Word formats:
  - Global header: [CLIQUE_W-1:0]=init_maxsize, [31]=nocliques, all other bits 0.
  - Problem header: [VERTS_W-1:0]=nverts, [31]=1 only for problem index nprobs-1, all other bits 0.
  - Payload per problem: nverts rows of ceil(nverts/32) words, i.e. nverts*ceil(nverts/32) words.
  - Payload is read from consecutive addresses; address 0 holds problem 0's first word; problems are packed back-to-back.
- Address and width rules:
  - Word count is computed at full width (VERTS_W*2 bits).
  - The address counter is ADDR_W bits and wraps modulo 2^ADDR_W without error.
- Buffering:
  - All words pass through a 2-entry FIFO.
  - A memory read is issued only when (fifo_count + reads_in_flight) < 2, so the FIFO never overflows.
  - Sustained throughput is 1 word/cycle with want held high.
- State machine, in order:
  - S_IDLE: start with nprobs!=0 → S_GLOBAL_HEADER. Start with nprobs==0 → o_done the next cycle, nothing emitted, o_busy stays 0.
  - S_GLOBAL_HEADER: push the global header → S_DESC_RD.
  - S_DESC_RD: present prob_idx on o_desc_addr for 1 cycle, capture nverts the next cycle → S_PROBLEM_HEADER.
  - S_PROBLEM_HEADER: push the header. If payload count==0 (nverts==0), skip to next-problem handling. Otherwise → S_PAYLOAD.
  - S_PAYLOAD: issue reads until remaining==0. Then, if this is the last problem → S_DRAIN; else prob_idx++ → S_DESC_RD.
  - S_DRAIN: wait for the FIFO to be empty and no reads in flight → S_DONE.
  - S_DONE: o_done=1 for one cycle → S_IDLE.
- Latency: the global header is presented (have=1) 2 cycles after the accepted start pulse.
- start while busy is ignored.
- Reset values:
  - All outputs 0 (o_outdata 0, have 0, o_mem_rd 0, addresses 0).
  - FIFO emptied, in-flight count 0.
  - state=S_IDLE, address counter 0.
- Reset mid-stream: everything above is cleared immediately and asynchronously. A read-data return arriving after reset deassertion is discarded.

Optional Feature:
- Macro PROBLEM_STREAM_TX_WORDCOUNT_EN.
- Defined: adds output o_dbg_words [31:0].
  - Counts completed transfers (headers included).
  - Cleared on accepted start and on reset.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared defs package/header holds:
  - state encodings;
  - header bit positions (LASTPROB/NOCLIQUES bit 31);
  - a words-per-row function ceil(n/32).
- One sub-module, stream_skid_fifo: 2-entry, 32-bit, have/want out, push/count in.

Test Plan:
- nprobs=1, nverts=3, maxsize=2, nocliques=0, want=1 → words 32'h00000002, 32'h80000003, mem[0..2]; o_done once; o_busy low after.
- nprobs=2, nverts 40 and 5 → 32'h80000000|maxsize global with nocliques=1; header 0x28 with bit31=0, 80 payload words (addr 0..79); header 0x80000005, 5 words (addr 80..84).
- Random want toggling (50%) on case 2 → identical word sequence; data stable while have&&!want; no FIFO overflow.
- nverts=0 in the middle problem of 3 → its header is emitted with no payload; address does not advance.
- nprobs=0 start → o_done next cycle, have never asserted; start pulse during busy → ignored, stream unchanged.
- Assert i_reset_n low mid-payload → have=0 and o_mem_rd=0 immediately; after release, a new start with nprobs=1, nverts=3 produces the correct stream beginning at address 0.
